// File: rtl/mem_block_ctrl_pkg.sv
// Shared main-memory constants and FSM encoding.
// The cache controller imports the same package so both sides agree on block geometry.
package mem_block_ctrl_pkg;

  localparam int BLOCK_W         = 128;
  localparam int WORD_W          = 32;
  localparam int WORDS_PER_BLOCK = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mem_block_array.sv
// Block-wide storage: synchronous 4-word write, combinational block read.
// At time zero each word holds its own word index.
module mem_block_array
  import mem_block_ctrl_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_W-5:0]   blk_addr,
  input  logic [BLOCK_W-1:0]  wdata,
  output logic [BLOCK_W-1:0]  rdata
);

  localparam int NBLK = 2 ** (ADDR_W - 4);

  function automatic logic [NBLK*BLOCK_W-1:0] init_mem();
    logic [NBLK*BLOCK_W-1:0] v;
    for (int i = 0; i < NBLK * WORDS_PER_BLOCK; i++) begin
      v[i*WORD_W +: WORD_W] = WORD_W'(i);
    end
    return v;
  endfunction

  logic [NBLK*BLOCK_W-1:0] r_mem = init_mem();

  // NOTE: storage has no reset; a reset must not wipe memory contents, only the control state.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[int'(blk_addr)*BLOCK_W +: BLOCK_W] <= wdata;
    end
  end

  assign rdata = r_mem[int'(blk_addr)*BLOCK_W +: BLOCK_W];

endmodule

// File: rtl/mem_block_ctrl.sv
// Main-memory block controller: accepts one block read/write, waits a fixed
// latency, then commits the access and pulses resp_valid for one cycle.
module mem_block_ctrl
  import mem_block_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [BLOCK_W-1:0] req_wdata,
  output logic               resp_valid,
  output logic [BLOCK_W-1:0] resp_rdata,
  output logic               busy
);

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic [ADDR_W-5:0]   r_blk;
  logic                r_write;
  logic [BLOCK_W-1:0]  r_wdata;
  logic                r_ready;
  logic                r_busy;
  logic                r_resp_valid;
  logic [BLOCK_W-1:0]  r_resp_rdata;

  logic                w_access;
  logic                w_we;
  logic [BLOCK_W-1:0]  w_rdata;
  logic                w_unused_offset;

  // Byte offset within the block is irrelevant to whole-block transfers.
  assign w_unused_offset = &{1'b0, req_addr[3:0]};

  assign w_access = (r_state == ST_BUSY) && (r_cnt == 4'd0);
  assign w_we     = w_access && r_write;

  mem_block_array #(.ADDR_W(ADDR_W)) u_array (
    .clk      (clk),
    .we       (w_we),
    .blk_addr (r_blk),
    .wdata    (r_wdata),
    .rdata    (w_rdata)
  );

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 4'd0;
      r_blk        <= '0;
      r_write      <= 1'b0;
      r_wdata      <= '0;
      r_ready      <= 1'b1;
      r_busy       <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_blk   <= req_addr[ADDR_W-1:4];
            r_write <= req_write;
            r_wdata <= req_wdata;
            r_cnt   <= CNT_INIT;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_resp_valid <= 1'b1;
            r_resp_rdata <= r_write ? '0 : w_rdata;
            r_state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_resp_valid <= 1'b0;
          r_ready      <= 1'b1;
          r_busy       <= 1'b0;
          r_state      <= ST_IDLE;
        end
        default: begin
          r_resp_valid <= 1'b0;
          r_ready      <= 1'b1;
          r_busy       <= 1'b0;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = r_ready;
  assign busy       = r_busy;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;

endmodule
